// File: rtl/ifid_skid_reg.sv
// IF/ID pipeline register: valid/ready handshake, 2-entry skid buffer, synchronous flush, rs/rt pre-decode.
// Optional decode-bubble counter is built when IFID_PERF_EN is defined; otherwise bubble_cnt is tied to 0.
module ifid_skid_reg #(
  parameter int WORD_W = 32,
  parameter int ADDR_W = 32,
  parameter int REG_W  = 5,
  parameter int CNT_W  = 16
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              if_valid,
  output logic              if_ready,
  input  logic [WORD_W-1:0] if_instr,
  input  logic [ADDR_W-1:0] if_jaddr,
  input  logic              flush,
  output logic              id_valid,
  input  logic              id_ready,
  output logic [WORD_W-1:0] id_instr,
  output logic [ADDR_W-1:0] id_jaddr,
  output logic [REG_W-1:0]  id_rsel1,
  output logic [REG_W-1:0]  id_rsel2,
  output logic [CNT_W-1:0]  bubble_cnt,
  output logic [1:0]        dbg_state
);

  // Handshake: a word moves on if_* when if_valid & if_ready, and on id_* when id_valid & id_ready.
  // The sender holds valid and data until the transfer; id_* stay stable while id_valid & !id_ready.
  // State bits are {main_valid, skid_valid}, so both valid flags come straight off the state flops.
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    FULL  = 2'b10,
    SKID  = 2'b11
  } state_t;

  state_t state, state_n;

  logic acc, take;
  logic load_in, load_skid, skid_we, zero_main;

  logic [WORD_W-1:0] skid_instr;
  logic [ADDR_W-1:0] skid_jaddr;

  assign if_ready  = ~state[0];
  assign id_valid  = state[1];
  assign dbg_state = state;

  assign acc  = if_valid & if_ready;
  assign take = id_valid & id_ready;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) state <= EMPTY;
    else       state <= state_n;
  end

  always_comb begin
    state_n   = state;
    load_in   = 1'b0;
    load_skid = 1'b0;
    skid_we   = 1'b0;
    zero_main = 1'b0;
    if (flush) begin
      state_n   = EMPTY;
      zero_main = 1'b1;
    end else begin
      case (state)
        EMPTY: begin
          if (acc) begin
            state_n = FULL;
            load_in = 1'b1;
          end
        end
        FULL: begin
          if (acc && take) begin
            load_in = 1'b1;
          end else if (acc) begin
            state_n = SKID;
            skid_we = 1'b1;
          end else if (take) begin
            state_n = EMPTY;
          end
        end
        SKID: begin
          if (take) begin
            state_n   = FULL;
            load_skid = 1'b1;
          end
        end
        default: state_n = EMPTY;
      endcase
    end
  end

  // Pre-decode is recomputed from whichever word lands in main, including the skid refill.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      id_instr <= '0;
      id_jaddr <= '0;
      id_rsel1 <= '0;
      id_rsel2 <= '0;
    end else if (zero_main) begin
      id_instr <= '0;
      id_jaddr <= '0;
      id_rsel1 <= '0;
      id_rsel2 <= '0;
    end else if (load_in) begin
      id_instr <= if_instr;
      id_jaddr <= if_jaddr;
      id_rsel1 <= if_instr[21+REG_W-1:21];
      id_rsel2 <= if_instr[16+REG_W-1:16];
    end else if (load_skid) begin
      id_instr <= skid_instr;
      id_jaddr <= skid_jaddr;
      id_rsel1 <= skid_instr[21+REG_W-1:21];
      id_rsel2 <= skid_instr[16+REG_W-1:16];
    end
  end

  // Skid payload is only meaningful while skid_valid, so it carries no reset.
  always_ff @(posedge CLK) begin
    if (skid_we) begin
      skid_instr <= if_instr;
      skid_jaddr <= if_jaddr;
    end
  end

`ifdef IFID_PERF_EN
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  logic [CNT_W-1:0] bubble_q;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      bubble_q <= '0;
    end else if (!id_valid && id_ready && !flush && bubble_q != CNT_MAX) begin
      bubble_q <= bubble_q + CNT_ONE;
    end
  end

  assign bubble_cnt = bubble_q;
`else
  assign bubble_cnt = '0;
`endif

endmodule

// File: tb/tb_ifid_skid_reg.sv
// Self-checking bench for ifid_skid_reg: directed vector table, reset/flush/counter sequences,
// and a randomized phase checked against a queue-based model of the held instructions.
module tb_ifid_skid_reg;

  localparam int CNT_W = 4;
`ifdef IFID_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic             CLK = 1'b0;
  logic             nRST = 1'b0;
  logic             if_valid = 1'b0;
  logic             if_ready;
  logic [31:0]      if_instr = '0;
  logic [31:0]      if_jaddr = '0;
  logic             flush = 1'b0;
  logic             id_valid;
  logic             id_ready = 1'b0;
  logic [31:0]      id_instr;
  logic [31:0]      id_jaddr;
  logic [4:0]       id_rsel1;
  logic [4:0]       id_rsel2;
  logic [CNT_W-1:0] bubble_cnt;
  logic [1:0]       dbg_state;

  int tests = 0;
  int fails = 0;

  // Scoreboard: words held by the register, oldest first.
  logic [31:0] exp_q[$];
  logic [31:0] jq[$];
  int          exp_cnt;

  ifid_skid_reg #(.WORD_W(32), .ADDR_W(32), .REG_W(5), .CNT_W(CNT_W)) dut (
    .CLK(CLK), .nRST(nRST),
    .if_valid(if_valid), .if_ready(if_ready), .if_instr(if_instr), .if_jaddr(if_jaddr),
    .flush(flush),
    .id_valid(id_valid), .id_ready(id_ready), .id_instr(id_instr), .id_jaddr(id_jaddr),
    .id_rsel1(id_rsel1), .id_rsel2(id_rsel2), .bubble_cnt(bubble_cnt), .dbg_state(dbg_state)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic        iv;
    logic [31:0] w;
    logic        fl;
    logic        ir;
    logic        ev;
    logic        er;
    logic        cd;
    logic [31:0] ew;
    logic [4:0]  e1;
    logic [4:0]  e2;
  } vec_t;

  vec_t tbl[17];

  function automatic logic [31:0] ja(input logic [31:0] w);
    return {w[15:0], w[31:16]};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic iv, input logic [31:0] w, input logic [31:0] j,
                       input logic fl, input logic ir);
    if_valid = iv;
    if_instr = w;
    if_jaddr = j;
    flush    = fl;
    id_ready = ir;
  endtask

  task automatic do_reset();
    @(negedge CLK);
    nRST = 1'b0;
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    repeat (2) @(negedge CLK);
    nRST = 1'b1;
    exp_q.delete();
    jq.delete();
    exp_cnt = 0;
  endtask

  task automatic check_model();
    logic [31:0] w;
    chk("if_ready", if_ready, exp_q.size() < 2);
    chk("id_valid", id_valid, exp_q.size() > 0);
    if (exp_q.size() > 0) begin
      w = exp_q[0];
      chk("id_instr", id_instr, w);
      chk("id_jaddr", id_jaddr, jq[0]);
      chk("id_rsel1", id_rsel1, w[25:21]);
      chk("id_rsel2", id_rsel2, w[20:16]);
    end
    chk("bubble_cnt", bubble_cnt, PERF ? exp_cnt : 0);
  endtask

  initial begin
    logic        pend;
    logic [31:0] pw, pj;
    logic        iv, fl, ir, acc_m, take_m;
    logic [31:0] w, j;

    // A=8C220004 (rs1 rt2), B=00431020 (rs2 rt3), C=08000010 (0/0)
    tbl[0]  = '{1'b1, 32'h8C220004, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 32'h8C220004, 5'd1, 5'd2};
    tbl[1]  = '{1'b1, 32'h00431020, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 32'h00431020, 5'd2, 5'd3};
    tbl[2]  = '{1'b1, 32'h08000010, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 32'h08000010, 5'd0, 5'd0};
    tbl[3]  = '{1'b0, 32'h00000000, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h00000000, 5'd0, 5'd0};
    tbl[4]  = '{1'b1, 32'h8C220004, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'h8C220004, 5'd1, 5'd2};
    tbl[5]  = '{1'b1, 32'h00431020, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h8C220004, 5'd1, 5'd2};
    tbl[6]  = '{1'b1, 32'h08000010, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h8C220004, 5'd1, 5'd2};
    tbl[7]  = '{1'b1, 32'h08000010, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 32'h00431020, 5'd2, 5'd3};
    tbl[8]  = '{1'b1, 32'h08000010, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 32'h08000010, 5'd0, 5'd0};
    tbl[9]  = '{1'b0, 32'h00000000, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h00000000, 5'd0, 5'd0};
    tbl[10] = '{1'b1, 32'h8C220004, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'h8C220004, 5'd1, 5'd2};
    tbl[11] = '{1'b1, 32'h00431020, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h8C220004, 5'd1, 5'd2};
    tbl[12] = '{1'b1, 32'h08000010, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'h00000000, 5'd0, 5'd0};
    tbl[13] = '{1'b0, 32'h00000000, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 32'h00000000, 5'd0, 5'd0};
    tbl[14] = '{1'b1, 32'h8C220004, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'h8C220004, 5'd1, 5'd2};
    tbl[15] = '{1'b1, 32'h00431020, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 32'h00000000, 5'd0, 5'd0};
    tbl[16] = '{1'b0, 32'h00000000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h00000000, 5'd0, 5'd0};

    // Values while reset is held
    #12;
    chk("rst_id_valid", id_valid, 1'b0);
    chk("rst_if_ready", if_ready, 1'b1);
    chk("rst_id_instr", id_instr, 32'h0);
    chk("rst_id_jaddr", id_jaddr, 32'h0);
    chk("rst_rsel1", id_rsel1, 5'd0);
    chk("rst_rsel2", id_rsel2, 5'd0);
    chk("rst_bubble", bubble_cnt, 0);
    @(negedge CLK);
    nRST = 1'b1;

    // Directed vector table
    for (int i = 0; i < 17; i++) begin
      @(negedge CLK);
      drive(tbl[i].iv, tbl[i].w, ja(tbl[i].w), tbl[i].fl, tbl[i].ir);
      @(posedge CLK);
      #1;
      chk($sformatf("vec%0d_valid", i), id_valid, tbl[i].ev);
      chk($sformatf("vec%0d_ready", i), if_ready, tbl[i].er);
      chk($sformatf("vec%0d_state", i), dbg_state, {tbl[i].ev, ~tbl[i].er});
      if (tbl[i].cd) begin
        chk($sformatf("vec%0d_instr", i), id_instr, tbl[i].ew);
        chk($sformatf("vec%0d_jaddr", i), id_jaddr, ja(tbl[i].ew));
        chk($sformatf("vec%0d_rsel1", i), id_rsel1, tbl[i].e1);
        chk($sformatf("vec%0d_rsel2", i), id_rsel2, tbl[i].e2);
      end
    end

    // Asynchronous reset while the skid slot is occupied
    @(negedge CLK);
    drive(1'b1, 32'h8C220004, 32'h11, 1'b0, 1'b0);
    @(negedge CLK);
    drive(1'b1, 32'h00431020, 32'h22, 1'b0, 1'b0);
    @(posedge CLK);
    #1;
    chk("pre_rst_state", dbg_state, 2'b11);
    #2;
    nRST = 1'b0;
    #1;
    chk("arst_id_valid", id_valid, 1'b0);
    chk("arst_id_instr", id_instr, 32'h0);
    chk("arst_if_ready", if_ready, 1'b1);
    chk("arst_id_jaddr", id_jaddr, 32'h0);
    @(negedge CLK);
    nRST = 1'b1;
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(posedge CLK);
      #1;
      chk("post_rst_valid", id_valid, 1'b0);
      chk("post_rst_instr", id_instr, 32'h0);
      chk("post_rst_ready", if_ready, 1'b1);
    end

    // Bubble counter: flush cycles not counted, then saturation
    do_reset();
    drive(1'b0, '0, '0, 1'b1, 1'b1);
    repeat (3) @(negedge CLK);
    chk("bubble_flush", bubble_cnt, 0);
    drive(1'b0, '0, '0, 1'b0, 1'b1);
    repeat (5) @(negedge CLK);
    chk("bubble_5", bubble_cnt, PERF ? 5 : 0);
    repeat (15) @(negedge CLK);
    chk("bubble_sat", bubble_cnt, PERF ? 15 : 0);

    // Randomized traffic against the queue model
    do_reset();
    pend = 1'b0;
    pw = '0;
    pj = '0;
    for (int c = 0; c < 400; c++) begin
      @(negedge CLK);
      check_model();
      if (pend) begin
        iv = 1'b1;
        w  = pw;
        j  = pj;
      end else begin
        iv = ($urandom_range(0, 3) != 0);
        w  = $urandom();
        j  = $urandom();
      end
      fl = ($urandom_range(0, 11) == 0);
      ir = ($urandom_range(0, 3) != 0);
      drive(iv, w, j, fl, ir);
      acc_m  = iv && (exp_q.size() < 2);
      take_m = ir && (exp_q.size() > 0);
      if (exp_q.size() == 0 && ir && !fl && exp_cnt < 15) exp_cnt++;
      if (fl) begin
        exp_q.delete();
        jq.delete();
      end else begin
        if (take_m) begin
          void'(exp_q.pop_front());
          void'(jq.pop_front());
        end
        if (acc_m) begin
          exp_q.push_back(w);
          jq.push_back(j);
        end
      end
      pend = iv && !acc_m && !fl;
      pw   = w;
      pj   = j;
    end
    @(negedge CLK);
    check_model();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
